// File: rtl/mcs_fpro_pkg.sv
// mcs_fpro_pkg: shared types and constants for the MCS-to-FPro bridge.
//   brg_state_t : bridge sequencing states
//   brg_req_t   : latched request attributes (direction + subsystem select)
package mcs_fpro_pkg;

   localparam int unsigned DATA_W        = 32;
   localparam int unsigned IO_ADDR_W     = 32;
   localparam int unsigned FP_ADDR_W     = 21;
   localparam int unsigned VIDEO_SEL_BIT = 23;
   localparam int unsigned WAIT_CNT_W    = 4;

   // Read data returned for writes and for accesses outside the bridge window
   localparam logic [DATA_W-1:0] OOW_RD_DATA = 32'h0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STROBE,
      ST_WAIT,
      ST_DONE
   } brg_state_t;

   typedef struct packed {
      logic wr;
      logic mmio;
      logic video;
   } brg_req_t;

endpackage

// File: rtl/mcs_fpro_bridge.sv
// mcs_fpro_bridge: registers one MCS I/O request, issues a single-cycle FPro
// strobe to the MMIO or video subsystem, holds the address for WAIT_CYC cycles,
// then returns captured read data with a one-cycle io_ready pulse.
// Ports:
//   clk, reset (async, active-low)
//   io_*      : MCS I/O bus (request in, io_read_data/io_ready out)
//   fp_*      : FPro bus (cs/rd/wr/addr/wr_data out, per-subsystem rd_data in)
//   ovr       : sticky protocol-error flag (dropped request or rd+wr together)
module mcs_fpro_bridge
   import mcs_fpro_pkg::*;
#(
   parameter logic [31:0]  BRG_BASE = 32'hC000_0000,
   parameter int unsigned  WAIT_CYC = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 io_addr_strobe,
   input  logic                 io_read_strobe,
   input  logic                 io_write_strobe,
   input  logic [3:0]           io_byte_enable,
   input  logic [IO_ADDR_W-1:0] io_address,
   input  logic [DATA_W-1:0]    io_write_data,
   output logic [DATA_W-1:0]    io_read_data,
   output logic                 io_ready,
   output logic                 fp_mmio_cs,
   output logic                 fp_video_cs,
   output logic                 fp_wr,
   output logic                 fp_rd,
   output logic [FP_ADDR_W-1:0] fp_addr,
   output logic [DATA_W-1:0]    fp_wr_data,
   input  logic [DATA_W-1:0]    fp_mmio_rd_data,
   input  logic [DATA_W-1:0]    fp_video_rd_data,
   output logic                 ovr
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      WAIT_CNT_W'((WAIT_CYC == 0) ? 0 : WAIT_CYC - 1);

   brg_state_t             state, state_nxt;
   brg_req_t               req, req_nxt;
   logic [WAIT_CNT_W-1:0]  cnt, cnt_nxt;
   logic [FP_ADDR_W-1:0]   fp_addr_nxt;
   logic [DATA_W-1:0]      fp_wr_data_nxt, io_read_data_nxt, rd_capture;
   logic                   fp_mmio_cs_nxt, fp_video_cs_nxt, fp_wr_nxt, fp_rd_nxt;
   logic                   io_ready_nxt, ovr_nxt;
   logic                   in_win, sel_mmio, sel_video;

   // Byte lanes and the byte offset have no meaning on the word-only FPro bus
   logic unused_ok;
   assign unused_ok = ^{io_byte_enable, io_address[1:0]};

   // Address decode: window hit, then bit 23 splits MMIO from video
   assign in_win    = (io_address[31:24] == BRG_BASE[31:24]);
   assign sel_mmio  = in_win && !io_address[VIDEO_SEL_BIT];
   assign sel_video = in_win &&  io_address[VIDEO_SEL_BIT];

   // Value latched into io_read_data on the last cycle before DONE
   assign rd_capture = req.wr    ? OOW_RD_DATA      :
                       req.mmio  ? fp_mmio_rd_data  :
                       req.video ? fp_video_rd_data : OOW_RD_DATA;

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         req          <= '0;
         cnt          <= '0;
         fp_addr      <= '0;
         fp_wr_data   <= '0;
         io_read_data <= '0;
         fp_mmio_cs   <= 1'b0;
         fp_video_cs  <= 1'b0;
         fp_wr        <= 1'b0;
         fp_rd        <= 1'b0;
         io_ready     <= 1'b0;
         ovr          <= 1'b0;
      end else begin
         state        <= state_nxt;
         req          <= req_nxt;
         cnt          <= cnt_nxt;
         fp_addr      <= fp_addr_nxt;
         fp_wr_data   <= fp_wr_data_nxt;
         io_read_data <= io_read_data_nxt;
         fp_mmio_cs   <= fp_mmio_cs_nxt;
         fp_video_cs  <= fp_video_cs_nxt;
         fp_wr        <= fp_wr_nxt;
         fp_rd        <= fp_rd_nxt;
         io_ready     <= io_ready_nxt;
         ovr          <= ovr_nxt;
      end
   end

   // Next-state and next-output logic; strobes and io_ready default low
   always_comb begin
      state_nxt        = state;
      req_nxt          = req;
      cnt_nxt          = cnt;
      fp_addr_nxt      = fp_addr;
      fp_wr_data_nxt   = fp_wr_data;
      io_read_data_nxt = io_read_data;
      ovr_nxt          = ovr;
      fp_mmio_cs_nxt   = 1'b0;
      fp_video_cs_nxt  = 1'b0;
      fp_wr_nxt        = 1'b0;
      fp_rd_nxt        = 1'b0;
      io_ready_nxt     = 1'b0;

      // No queueing: a request arriving while busy is lost and flagged
      if (io_addr_strobe && (state != ST_IDLE)) begin
         ovr_nxt = 1'b1;
      end

      case (state)
         ST_IDLE: begin
            if (io_addr_strobe) begin
               // Write wins when both strobes are set; neither means read
               req_nxt.wr      = io_write_strobe;
               req_nxt.mmio    = sel_mmio;
               req_nxt.video   = sel_video;
               fp_addr_nxt     = io_address[VIDEO_SEL_BIT-1:2];
               fp_wr_data_nxt  = io_write_data;
               fp_mmio_cs_nxt  = sel_mmio;
               fp_video_cs_nxt = sel_video;
               fp_wr_nxt       = in_win &&  io_write_strobe;
               fp_rd_nxt       = in_win && !io_write_strobe;
               if (io_read_strobe && io_write_strobe) begin
                  ovr_nxt = 1'b1;
               end
               state_nxt = ST_STROBE;
            end
         end
         ST_STROBE: begin
            if (WAIT_CYC == 0) begin
               io_read_data_nxt = rd_capture;
               io_ready_nxt     = 1'b1;
               state_nxt        = ST_DONE;
            end else begin
               cnt_nxt   = WAIT_LOAD;
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt == '0) begin
               io_read_data_nxt = rd_capture;
               io_ready_nxt     = 1'b1;
               state_nxt        = ST_DONE;
            end else begin
               cnt_nxt = cnt - WAIT_CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
